// File: rtl/nn_mac_sequencer.sv
// nn_mac_sequencer: drives one shared multiply-accumulate unit through a
// two-layer (N_IN -> N_HID -> 1) network evaluation. Control and address
// outputs are decoded from the next state and counter values and then
// registered, so every output is a clean flop output that is aligned with
// the state it describes.
module nn_mac_sequencer #(
  parameter int N_IN  = 7,
  parameter int N_HID = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [2:0] x_sel,
  output logic [3:0] h_sel,
  output logic [6:0] w_addr,
  output logic       src_hid,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       h_wr,
  output logic       y_wr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HCLR = 3'd1,
    S_HMAC = 3'd2,
    S_HWR  = 3'd3,
    S_OCLR = 3'd4,
    S_OMAC = 3'd5,
    S_OWR  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  // Terminal counter values and the base address of the output-layer weights.
  localparam logic [2:0] I_LAST = 3'(N_IN - 1);
  localparam logic [3:0] H_LAST = 4'(N_HID - 1);
  localparam logic [6:0] N_IN_W = 7'(N_IN);
  localparam logic [6:0] O_BASE = 7'(N_IN * N_HID);

  state_t     state, state_nx;
  logic [2:0] i_cnt, i_nx;
  logic [3:0] h_cnt, h_nx;
  logic [3:0] k_cnt, k_nx;

  logic       busy_nx, done_nx, src_hid_nx;
  logic       mac_clr_nx, mac_en_nx, h_wr_nx, y_wr_nx;
  logic [2:0] x_sel_nx;
  logic [3:0] h_sel_nx;
  logic [6:0] w_addr_nx;

  // State and counter registers; reset parks the sequencer in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      i_cnt <= 3'd0;
      h_cnt <= 4'd0;
      k_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      i_cnt <= i_nx;
      h_cnt <= h_nx;
      k_cnt <= k_nx;
    end
  end

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    i_nx     = i_cnt;
    h_nx     = h_cnt;
    k_nx     = k_cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_HCLR;
          i_nx     = 3'd0;
          h_nx     = 4'd0;
          k_nx     = 4'd0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_HCLR: begin
        state_nx = S_HMAC;
        i_nx     = 3'd0;
      end
      S_HMAC: begin
        if (i_cnt == I_LAST) begin
          state_nx = S_HWR;
          i_nx     = 3'd0;
        end else begin
          i_nx     = i_cnt + 3'd1;
        end
      end
      S_HWR: begin
        if (h_cnt == H_LAST) begin
          state_nx = S_OCLR;
        end else begin
          state_nx = S_HCLR;
          h_nx     = h_cnt + 4'd1;
        end
      end
      S_OCLR: begin
        state_nx = S_OMAC;
        k_nx     = 4'd0;
      end
      S_OMAC: begin
        if (k_cnt == H_LAST) begin
          state_nx = S_OWR;
          k_nx     = 4'd0;
        end else begin
          k_nx     = k_cnt + 4'd1;
        end
      end
      S_OWR: begin
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
        i_nx     = 3'd0;
        h_nx     = 4'd0;
        k_nx     = 4'd0;
      end
      default: begin
        state_nx = S_IDLE;
        i_nx     = 3'd0;
        h_nx     = 4'd0;
        k_nx     = 4'd0;
      end
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      i_nx     = 3'd0;
      h_nx     = 4'd0;
      k_nx     = 4'd0;
    end else begin
      state_nx = state_nx;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    busy_nx    = (state_nx != S_IDLE);
    done_nx    = 1'b0;
    src_hid_nx = 1'b0;
    mac_clr_nx = 1'b0;
    mac_en_nx  = 1'b0;
    h_wr_nx    = 1'b0;
    y_wr_nx    = 1'b0;
    x_sel_nx   = 3'd0;
    h_sel_nx   = 4'd0;
    w_addr_nx  = 7'd0;
    case (state_nx)
      S_HCLR: mac_clr_nx = 1'b1;
      S_HMAC: begin
        mac_en_nx = 1'b1;
        x_sel_nx  = i_nx;
        h_sel_nx  = h_nx;
        w_addr_nx = 7'(h_nx) * N_IN_W + 7'(i_nx);
      end
      S_HWR: begin
        h_wr_nx  = 1'b1;
        h_sel_nx = h_nx;
      end
      S_OCLR: mac_clr_nx = 1'b1;
      S_OMAC: begin
        mac_en_nx  = 1'b1;
        src_hid_nx = 1'b1;
        h_sel_nx   = k_nx;
        w_addr_nx  = O_BASE + 7'(k_nx);
      end
      S_OWR:  y_wr_nx = 1'b1;
      S_DONE: done_nx = 1'b1;
      default: busy_nx = busy_nx;
    endcase
  end

  // Output registers; reset clears every output for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      src_hid <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      h_wr    <= 1'b0;
      y_wr    <= 1'b0;
      x_sel   <= 3'd0;
      h_sel   <= 4'd0;
      w_addr  <= 7'd0;
    end else begin
      busy    <= busy_nx;
      done    <= done_nx;
      src_hid <= src_hid_nx;
      mac_clr <= mac_clr_nx;
      mac_en  <= mac_en_nx;
      h_wr    <= h_wr_nx;
      y_wr    <= y_wr_nx;
      x_sel   <= x_sel_nx;
      h_sel   <= h_sel_nx;
      w_addr  <= w_addr_nx;
    end
  end

endmodule

// File: doc/nn_mac_sequencer.md
NN_MAC_SEQUENCER -- requirements
Module: nn_mac_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_IN, 7, network inputs per hidden neuron
- N_HID, 13, hidden neurons (also output-neuron fan-in)
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request one full network evaluation
- abort  in  1  cancel evaluation in progress
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse, output neuron result captured
- x_sel  out  3  input operand index, 0..N_IN-1
- h_sel  out  4  hidden neuron index / hidden operand index, 0..N_HID-1
- w_addr  out  7  weight address; hidden weights h*N_IN+i (0..90), output weights 91+k (91..103)
- src_hid  out  1  MAC operand source: 0 = x[x_sel], 1 = hidden register[h_sel]
- mac_clr  out  1  clear shared accumulator
- mac_en  out  1  accumulate operand*weight this cycle
- h_wr  out  1  write activated accumulator into hidden register h_sel
- y_wr  out  1  write activated accumulator into output register

Function
REQ-003 The block SHALL sequence one shared MAC over the 7-13-1 network using FSM states IDLE, HCLR, HMAC, HWR, OCLR, OMAC, OWR, DONE.
REQ-004 IDLE SHALL go to HCLR when start=1; start SHALL be ignored in every other state.
REQ-005 HCLR SHALL assert mac_clr for one cycle, then go to HMAC with i=0.
REQ-006 HMAC SHALL last N_IN cycles with mac_en=1, src_hid=0, x_sel=i, h_sel=h, w_addr=h*N_IN+i, i incrementing 0..6, then go to HWR.
REQ-007 HWR SHALL assert h_wr for one cycle with h_sel=h; if h=N_HID-1 go to OCLR, else h increments and go to HCLR.
REQ-008 OCLR SHALL assert mac_clr for one cycle, then go to OMAC with k=0.
REQ-009 OMAC SHALL last N_HID cycles with mac_en=1, src_hid=1, h_sel=k, w_addr=91+k, k incrementing 0..12, then go to OWR.
REQ-010 OWR SHALL assert y_wr for one cycle, then go to DONE.
REQ-011 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-012 Latency: start sampled at edge 0 SHALL give first HCLR cycle 1, last HWR cycle 117, OWR cycle 132, done in cycle 133.
REQ-013 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-014 mac_clr, mac_en, h_wr, y_wr, done SHALL be 0 outside the states named for them; at most one of mac_clr, mac_en, h_wr, y_wr SHALL be 1 in any cycle.
REQ-015 x_sel, h_sel, w_addr, src_hid SHALL be 0 in IDLE and DONE.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE at the next edge: no done, no further h_wr/y_wr; abort SHALL take priority over every transition.
REQ-017 abort=1 in IDLE together with start=1 SHALL leave the block in IDLE.
REQ-018 Counters i, h, k SHALL never exceed 6, 12, 12; w_addr SHALL never exceed 103.
REQ-019 start=1 during the DONE cycle SHALL be ignored; a new evaluation SHALL need start in IDLE.

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, clear i, h, k, and give all outputs 0 from the next cycle, regardless of state or of start/abort.
REQ-021 rst SHALL take priority over abort and start.

Verification
REQ-022 Scenarios the bench SHALL cover:
- start pulse after reset -> HCLR cycle 1; 13 h_wr pulses with h_sel 0..12; y_wr cycle 132; done cycle 133; busy high cycles 1..133; 104 mac_en cycles total.
- Address trace -> hidden neuron 12, input 6: w_addr=90, x_sel=6; output phase w_addr 91..103 with h_sel 0..12, src_hid=1.
- start held high for 200 cycles -> second evaluation starts the cycle after done returns to IDLE; no restart mid-run.
- abort in cycle 50 (HMAC, h=5) -> IDLE cycle 51, busy=0, no done; a fresh start gives the full 133-cycle sequence.
- rst in cycle 125 (OMAC) -> all outputs 0 next cycle; no y_wr or done.
- start with abort both high in IDLE -> busy stays 0.
